// File: rtl/dma_rd_engine_if.sv
// dma_rd_engine_if: AXI4 read-address and read-data channels between a read master and the interconnect.
//   AW, DW          : address / data width
//   m_ar*           : AR channel (araddr, arlen, arsize, arburst, arvalid, arready)
//   m_r*            : R channel (rdata, rresp, rlast, rvalid, rready)
//   master / slave  : modports for the requesting engine and the responding memory side
interface dma_rd_engine_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    modport master (
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
    );
    modport slave (
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
    );
endinterface

// File: rtl/dma_rd_engine.sv
// dma_rd_engine: single-channel AXI4 read master splitting a DMA read request into INCR bursts.
//   clk, rstn                 : clock, asynchronous active-low reset
//   start_dma, num_trans,
//   start_addr                : request (sampled in IDLE only), beat count, 4-byte aligned byte address
//   data_o, data_vld_o,
//   data_cnt_o                : registered beat stream with 0-based index within the request
//   busy, done, rd_err        : activity, one-cycle completion pulse, sticky error flag
//   m                         : AXI read channels (master modport)
//   Define DMA_RD_4K_SPLIT_EN to keep every burst inside a 4 KB address page.
module dma_rd_engine #(
    parameter int BIT_TRANS    = 18,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int BURST_MAX    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start_dma,
    input  logic [BIT_TRANS-1:0]    num_trans,
    input  logic [AXI_WIDTH_AD-1:0] start_addr,
    output logic [AXI_WIDTH_DA-1:0] data_o,
    output logic                    data_vld_o,
    output logic [BIT_TRANS-1:0]    data_cnt_o,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_err,
    dma_rd_engine_if.master         m
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
    localparam logic [BIT_TRANS-1:0] BMAX = BIT_TRANS'(BURST_MAX);
    state_t                  state, state_nxt;
    logic [AXI_WIDTH_AD-1:0] addr;
    logic [BIT_TRANS-1:0]    rem, rem_nxt, beat_cnt, cap, blen;
    logic [8:0]              burst_left;
    logic                    accept, beat, last;
    assign accept  = state == IDLE && start_dma;
    assign beat    = state == DATA && m.m_rvalid;
    assign last    = beat && m.m_rlast;
    // saturating so a late rlast cannot wrap the remaining count
    assign rem_nxt = rem == '0 ? '0 : rem - 1'b1;
`ifdef DMA_RD_4K_SPLIT_EN
    logic [10:0] to_4k;
    assign to_4k = 11'd1024 - {1'b0, addr[11:2]};
    assign cap   = BIT_TRANS'(to_4k) < BMAX ? BIT_TRANS'(to_4k) : BMAX;
`else
    assign cap = BMAX;
`endif
    // addr/rem only move on R beats, so the AR fields stay stable while arvalid waits
    assign blen        = rem < cap ? rem : cap;
    assign m.m_arvalid = state == ADDR;
    assign m.m_araddr  = addr;
    assign m.m_arlen   = state == ADDR ? 8'(blen - 1'b1) : '0;
    assign m.m_arsize  = 3'd2;
    assign m.m_arburst = 2'b01;
    assign m.m_rready  = state == DATA;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !start_dma ? IDLE : (num_trans == '0 ? FIN : ADDR);
            ADDR:    state_nxt = m.m_arready ? DATA : ADDR;
            DATA:    state_nxt = !last ? DATA : (rem_nxt == '0 ? FIN : ADDR);
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr       <= '0;
            rem        <= '0;
            beat_cnt   <= '0;
            burst_left <= '0;
            data_o     <= '0;
            data_vld_o <= 1'b0;
            data_cnt_o <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            data_vld_o <= beat;
            done       <= state == FIN;
            if (beat) begin
                data_o     <= m.m_rdata;
                data_cnt_o <= beat_cnt;
                beat_cnt   <= beat_cnt + 1'b1;
                rem        <= rem_nxt;
                burst_left <= burst_left - 1'b1;
                addr       <= addr + AXI_WIDTH_AD'(4);
            end
            if (state == ADDR && m.m_arready) burst_left <= 9'(blen);
            if (beat && (m.m_rresp != 2'b00 || m.m_rlast != (burst_left == 9'd1))) rd_err <= 1'b1;
            if (accept) begin
                addr     <= start_addr;
                rem      <= num_trans;
                beat_cnt <= '0;
                rd_err   <= 1'b0;
                busy     <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: doc/dma_rd_engine.md
# dma_rd_engine

- Single-channel AXI4 read master that services the convolution layer's DMA read requests (`start_dma`, `num_trans`, `start_addr`).
- Splits each request into INCR bursts, issues them on AR, and returns read beats to the convolution datapath as a registered stream (`data_o`, `data_vld_o`, `data_cnt_o`).
- Sits between the convolution top and the external DDR AXI interconnect, feeding bias, weight and IFM fetches.

## Interface
- BIT_TRANS, 18, width of beat-count fields
- AXI_WIDTH_AD, 32, AXI address width
- AXI_WIDTH_DA, 32, AXI data width (one beat = 4 bytes)
- BURST_MAX, 16, maximum beats per burst (power of 2, ≤256)
- clk  in  1  clock; one clock domain
- rstn  in  1  reset, asynchronous, active-low
- start_dma  in  1  request pulse, sampled only in IDLE
- num_trans  in  BIT_TRANS  number of 32-bit beats to read
- start_addr  in  AXI_WIDTH_AD  byte address, 4-byte aligned
- data_o  out  AXI_WIDTH_DA  read data beat
- data_vld_o  out  1  data_o valid, one cycle per beat
- data_cnt_o  out  BIT_TRANS  index of the current beat within the request (0-based)
- busy  out  1  high from accepted start until the done pulse, inclusive
- done  out  1  one-cycle pulse when all beats are delivered
- rd_err  out  1  sticky error flag; cleared on the next accepted start
- m_araddr  out  AXI_WIDTH_AD  burst address
- m_arlen  out  8  beats-1
- m_arsize  out  3  constant 3'd2
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arvalid  out  1  address valid
- m_arready  in  1  address ready
- m_rdata  in  AXI_WIDTH_DA  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat of burst
- m_rvalid  in  1  read valid
- m_rready  out  1  read ready

## Operation
- **FSM:** IDLE → ADDR → DATA → (ADDR | FIN) → IDLE.
- **IDLE:**
  - On `start_dma`, latch `start_addr` and `num_trans` as remaining, clear `rd_err` and the beat counter, then set `busy`.
  - If `num_trans == 0`, go to FIN; otherwise go to ADDR.
  - `start_dma` is ignored outside IDLE.
- **ADDR:**
  - Burst length = min(remaining, BURST_MAX, beats left to the next 4 KB boundary when split is enabled).
  - Drive `m_araddr`/`m_arlen` and hold `m_arvalid` with stable fields until `m_arready`.
  - On handshake, go to DATA.
- **DATA:**
  - `m_rready` = 1. Each `m_rvalid` beat:
    - registers `m_rdata` to `data_o` with `data_vld_o` = 1;
    - sets `data_cnt_o` to the running beat index, which then increments;
    - decrements burst_left and remaining.
  - `m_rresp != 0` on any beat sets `rd_err`.
  - Burst ends on the beat with `m_rlast`. If `m_rlast` does not coincide with burst_left reaching 1, set `rd_err`; the burst still ends on `m_rlast`.
  - After the burst: remaining > 0 → ADDR, with the address advanced by 4×beats. Remaining == 0 → FIN.
- **FIN:** `done` = 1 for one cycle, `busy` = 0 on the next cycle, return to IDLE.
- **Outstanding bursts:** exactly one at a time; no AR is issued while R is pending.
- **Arithmetic:**
  - Address adds are modulo 2^AXI_WIDTH_AD.
  - Beats to the 4 KB boundary = (4096 − addr[11:0]) >> 2, range 1..1024.

## Timing
- **Reset values:** all outputs 0, except `m_arsize` = 2 and `m_arburst` = 1. FSM goes to IDLE.
- **Reset mid-operation:** the transfer is abandoned without completing the AXI handshake (system-wide reset assumed). No `done` is issued.
- **Start latency:** start in cycle N → `m_arvalid` high in cycle N+1.
- **Data latency:** R handshake in cycle N → `data_vld_o` in cycle N+1.
- **Burst turnaround:** last beat accepted in cycle N → next `m_arvalid` in N+1.
- **Done timing:** `done` occurs in the cycle after the final `data_vld_o`.
- **Zero-length request:** start in cycle N → `done` in N+2, and no AR is issued.
- **Backpressure:** none toward the consumer. The consumer must accept a beat every cycle.

## Configuration
- **`DMA_RD_4K_SPLIT_EN` defined:** bursts never cross a 4 KB address boundary (AXI-compliant).
- **`DMA_RD_4K_SPLIT_EN` undefined:** bursts are limited only by BURST_MAX and remaining, which saves the boundary subtractor. Use only when buffers are BURST_MAX×4-byte aligned.

## Test plan
- **Single burst:** start_addr=0x1000, num_trans=16, arready/rvalid always 1 → one AR (araddr 0x1000, arlen 15), 16 data_vld_o beats with data_cnt_o 0..15, `done` one cycle after the last beat, `rd_err`=0.
- **Multi-burst with remainder:** num_trans=37 at 0x0 → ARs at 0x0/0x40/0x80 with arlen 15/15/4, 37 beats delivered, data_cnt_o continuous 0..36.
- **4 KB split (macro on):** start_addr=0xFF8, num_trans=8 → AR 0xFF8 arlen 1, then AR 0x1000 arlen 5. With the macro off → a single AR arlen 7.
- **Stalls:** arready low 5 cycles, random rvalid gaps → arvalid/araddr stable while stalled, beat order and count unchanged, `busy` high throughout.
- **Errors:**
  - rresp=2 on beat 3 → `rd_err` set and held after `done`; the next start clears it.
  - Early rlast at beat 10 of 16 → `rd_err`=1.
- **Edge and reset cases:**
  - num_trans=0 → `done` at N+2 with no AR.
  - start_dma while busy → ignored.
  - rstn low mid-DATA → all outputs return to reset values asynchronously.
